// File: rtl/uart_rx_word_buffer_pkg.sv
// Shared types for the UART receive word buffer.
// Byte/word widths used by the assembler and the word FIFO.
package uart_rx_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

endpackage

// File: rtl/uart_rx_word_fifo.sv
// First-word fall-through word FIFO with MSB-wrap pointers.
// Head is read combinationally; while empty it shows the last popped word.
module uart_rx_word_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   PTR_ONE = 1;

    word_t                 mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] out_idx;

    assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
    assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2])
                && (wr_idx == rd_idx);
    assign count = wr_ptr - rd_ptr;

    // Looking one slot back while empty keeps the last word visible.
    assign out_idx = empty ? (rd_idx - IDX_ONE) : rd_idx;
    assign rdata   = mem[out_idx];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_idx] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx_word_buffer.sv
// Packs UART bytes (first byte in MSB) into 32-bit words queued in a FIFO.
// Define UART_RX_OVERRUN_COUNT_EN to add the saturating overrun_count output.
module uart_rx_word_buffer
    import uart_rx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  word_taken,
    input  logic                  flush,
    output logic                  input_ready,
    output logic [31:0]           input_data,
    output logic [DEPTH_LOG2:0]   word_count,
`ifdef UART_RX_OVERRUN_COUNT_EN
    output logic [15:0]           overrun_count,
`endif
    output logic                  overrun
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_cnt;
    logic [23:0] sh;
    word_t       word;
    logic        push_req;
    logic        push_ok;
    logic        pop_ok;
    logic        drop;
    logic        full;
    logic        empty;

    assign word     = {sh, rx_byte};
    assign push_req = rx_valid && (byte_cnt == LAST_BYTE) && !flush;
    assign pop_ok   = word_taken && !empty && !flush;
    // A full FIFO still accepts the word when the head leaves this cycle.
    assign push_ok  = push_req && (!full || pop_ok);
    assign drop     = push_req && !push_ok;

    assign input_ready = !empty;

    uart_rx_word_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push_ok),
        .pop   (pop_ok),
        .wdata (word),
        .rdata (input_data),
        .full  (full),
        .empty (empty),
        .count (word_count)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            byte_cnt <= '0;
            sh       <= '0;
            overrun  <= 1'b0;
        end else begin
            if (rx_valid) begin
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                    sh       <= {sh[15:0], rx_byte};
                end
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef UART_RX_OVERRUN_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            overrun_count <= '0;
        end else if (drop && (overrun_count != 16'hffff)) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_word_buffer.sv
// Directed bench for uart_rx_word_buffer: vector table plus
// hand-written FIFO full / overrun / reset sequences.
module tb_uart_rx_word_buffer;

    localparam int DL2 = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           rx_valid = 1'b0;
    logic [7:0]     rx_byte = 8'h00;
    logic           word_taken = 1'b0;
    logic           flush = 1'b0;
    logic           input_ready;
    logic [31:0]    input_data;
    logic [DL2:0]   word_count;
    logic           overrun;
`ifdef UART_RX_OVERRUN_COUNT_EN
    logic [15:0]    overrun_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_rx_word_buffer #(
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .word_taken    (word_taken),
        .flush         (flush),
        .input_ready   (input_ready),
        .input_data    (input_data),
        .word_count    (word_count),
`ifdef UART_RX_OVERRUN_COUNT_EN
        .overrun_count (overrun_count),
`endif
        .overrun       (overrun)
    );

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        t;
        logic        f;
        logic        er;
        logic [31:0] ed;
        logic        dchk;
        logic [3:0]  ec;
        logic        eo;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs; returns #1 after the capturing edge.
    task automatic step(input logic v, input logic [7:0] b,
                        input logic t, input logic f, input logic r);
        rx_valid   = v;
        rx_byte    = b;
        word_taken = t;
        flush      = f;
        reset      = r;
        @(posedge clk);
        #1;
        rx_valid   = 1'b0;
        rx_byte    = 8'h00;
        word_taken = 1'b0;
        flush      = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic take_last);
        step(1'b1, w[31:24], 1'b0, 1'b0, 1'b0);
        step(1'b1, w[23:16], 1'b0, 1'b0, 1'b0);
        step(1'b1, w[15:8],  1'b0, 1'b0, 1'b0);
        step(1'b1, w[7:0],   take_last, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[5]  = '{1'b1, 8'h78, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 4'd1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[8]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[9]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[10] = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[11] = '{1'b1, 8'hDD, 1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 1'b1, 4'd1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[13] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[14] = '{1'b1, 8'h98, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[16] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[17] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[18] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[19] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 32'h01020304, 1'b1, 4'd1, 1'b0};
        vecs[20] = '{1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[21] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[22] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[23] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
        vecs[24] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 32'h11223344, 1'b1, 4'd1, 1'b0};
        vecs[25] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};

        // Reset state
        do_reset();
        do_reset();
        check("rst_ready", 32'(input_ready), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data", input_data, 32'h0);

        // Vector table
        for (int i = 0; i < 26; i++) begin
            step(vecs[i].v, vecs[i].b, vecs[i].t, vecs[i].f, 1'b0);
            check($sformatf("vec%0d_ready", i), 32'(input_ready), 32'(vecs[i].er));
            check($sformatf("vec%0d_count", i), 32'(word_count), 32'(vecs[i].ec));
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].eo));
            if (vecs[i].dchk)
                check($sformatf("vec%0d_data", i), input_data, vecs[i].ed);
        end

        // Nine words into an eight-entry FIFO: last one dropped
        do_reset();
        for (int k = 0; k < 9; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            send_word({4{kb}}, 1'b0);
        end
        check("full_count", 32'(word_count), 32'd8);
        check("full_overrun", 32'(overrun), 32'd1);
`ifdef UART_RX_OVERRUN_COUNT_EN
        check("full_ovr_cnt", 32'(overrun_count), 32'd1);
`endif
        for (int k = 0; k < 8; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            check($sformatf("drain%0d_ready", k), 32'(input_ready), 32'd1);
            check($sformatf("drain%0d_data", k), input_data, {4{kb}});
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        check("drain_ready", 32'(input_ready), 32'd0);
        check("drain_count", 32'(word_count), 32'd0);
        check("drain_overrun", 32'(overrun), 32'd1);

        // Full FIFO, pop coincides with the 4th byte of a new word
        do_reset();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] kb;
            kb = 8'(k + 16);
            send_word({4{kb}}, 1'b0);
        end
        check("fp_count_pre", 32'(word_count), 32'd8);
        send_word(32'hA0A1A2A3, 1'b1);
        check("fp_count", 32'(word_count), 32'd8);
        check("fp_overrun", 32'(overrun), 32'd0);
        for (int k = 1; k < 8; k++) begin
            logic [7:0] kb;
            kb = 8'(k + 16);
            check($sformatf("fp%0d_data", k), input_data, {4{kb}});
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        check("fp_last_data", input_data, 32'hA0A1A2A3);
        check("fp_last_count", 32'(word_count), 32'd1);

        // Reset in the middle of a word
        do_reset();
        step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        do_reset();
        send_word(32'h01020304, 1'b0);
        check("rmw_ready", 32'(input_ready), 32'd1);
        check("rmw_data", input_data, 32'h01020304);
        check("rmw_count", 32'(word_count), 32'd1);

`ifdef UART_RX_OVERRUN_COUNT_EN
        // Overrun counter: three dropped words, then flush
        do_reset();
        for (int k = 0; k < 11; k++) begin
            logic [7:0] kb;
            kb = 8'(k + 32);
            send_word({4{kb}}, 1'b0);
        end
        check("oc_count", 32'(overrun_count), 32'd3);
        check("oc_overrun", 32'(overrun), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("oc_flush_count", 32'(overrun_count), 32'd0);
        check("oc_flush_overrun", 32'(overrun), 32'd0);
        check("oc_flush_ready", 32'(input_ready), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
